ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Consumes the raw byte stream of the PS/2 receive stage: SCAN_DATA plus the NEWDATA-style strobe from the PS2_CLK domain.
- Moves the stream into the system CLK domain and parses make, break (F0) and extended (E0) sequences.
- Maintains a held-key bitmap and produces debounced game commands.
- Feeds the snake game FSM with one buffered direction per game tick, rejecting 180-degree reversals.

Parameters:
- SYNC_STAGES, 2: flops in the strobe synchronizer chain (minimum 2).
- PREFIX_TIMEOUT, 1000000: CLK cycles the parser may stay in a prefix state before it is forced back to IDLE.
- RESET_DIR, 2'd1: direction loaded at reset (encoding below; 1 = RIGHT).

Ports:
- CLK, input, 1: system clock.
- RST, input, 1: synchronous, active-high reset.
- SCAN_STROBE, input, 1: asynchronous; high while SCAN_DATA holds a fresh byte (PS2_CLK domain).
- SCAN_DATA, input, 8: byte from the PS/2 receiver; stable from strobe rise until at least the next strobe rise.
- GAME_TICK, input, 1: one-cycle pulse from the game timer; commits the pending direction.
- DIR, output, 2: committed direction. UP=0, RIGHT=1, DOWN=2, LEFT=3.
- DIR_CHANGED, output, 1: one-cycle pulse when DIR takes a new value.
- KEYS_HELD, output, 8: bit per key. 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT, 4 ESC, 5 S, 6 P, 7 R.
- CMD_START, CMD_RESTART, CMD_ESC, output, 1 each: one-cycle pulses.
- PAUSED, output, 1: level; toggles on each P press.

Behaviour:
- Reset (RST high at a CLK edge):
  - DIR = RESET_DIR; pending direction = RESET_DIR.
  - KEYS_HELD = 0, PAUSED = 0, all pulse outputs 0.
  - Synchronizer flops = 0, parser = IDLE, timeout counter = 0.
  - Reset mid-sequence discards any prefix in progress.
- Strobe handling:
  - SCAN_STROBE passes through SYNC_STAGES flops; a rising edge of the last stage raises byte_valid for one cycle.
  - SCAN_DATA is captured into an 8-bit register on that cycle.
  - Latency: strobe rise to byte_valid is SYNC_STAGES+1 CLK cycles. Outputs update one cycle after byte_valid.
- Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> make(code, ext=1) -> IDLE.
  - BRK: any byte -> break(code, ext=0) -> IDLE.
  - EXT_BRK: any byte -> break(code, ext=1) -> IDLE.
  - Timeout: counter clears on every byte_valid and counts while not IDLE. Reaching PREFIX_TIMEOUT-1 forces IDLE with no event.
  - Byte 00 is an error/overrun code: ignored in every state and does not clear a prefix.
- Key map:
  - Arrows: 75 UP, 74 RIGHT, 72 DOWN, 6B LEFT. Accepted with ext=0 (keypad) or ext=1 (cursor keys).
  - Other keys, ext=0 only: 76 ESC, 1B S, 4D P, 2D R.
  - Unmapped codes change nothing.
- make(k):
  - If KEYS_HELD[k] is already set (typematic repeat), no command pulse fires. The bit stays set.
  - Otherwise set KEYS_HELD[k] and:
    - arrow: pending = d if d != (DIR ^ 2); else the press is discarded.
    - S: CMD_START pulse, PAUSED cleared.
    - P: PAUSED toggles.
    - R: CMD_RESTART pulse.
    - ESC: CMD_ESC pulse.
- break(k): clear KEYS_HELD[k]. A break for an unheld key is harmless.
- Direction commit:
  - On GAME_TICK, DIR <= pending. DIR_CHANGED pulses iff pending != DIR.
  - The reversal check always compares against committed DIR, never pending. The last valid press before the tick wins.
  - If a make and GAME_TICK occur in the same cycle, the tick commits the old pending value. The new value is committed on the next tick.
- CMD_RESTART additionally sets pending = RESET_DIR. DIR updates at the next tick.

Decomposition:
- Shared package ps2_pkg:
  - scan code constants: E0, F0, arrow codes, ESC, S, P, R.
  - direction typedef dir_t with UP/RIGHT/DOWN/LEFT.
  - KEYS_HELD bit index constants.
  - parser state enum.
- One sub-module: ps2_strobe_sync (parameterised synchronizer chain plus rising-edge detect), reused by any other PS2_CLK-domain consumer.

Test Plan:
- Reset then bytes E0 75, F0... sequence: send E0 75 -> KEYS_HELD[0]=1, pending=UP. Pulse GAME_TICK -> DIR=0, DIR_CHANGED for exactly one cycle.
- With DIR=RIGHT, send 6B (LEFT, keypad) then tick -> DIR stays 1, no DIR_CHANGED. Then send 72 and tick -> DIR=2.
- Send 4D three times (typematic) -> PAUSED=1 only once. Send F0 4D then 4D -> PAUSED=0.
- Send E0, then wait PREFIX_TIMEOUT cycles, then 74 -> parsed as ext=0 RIGHT via IDLE path, not as stuck EXT. Also E0 F0 74 -> KEYS_HELD[1] cleared.
- Assert RST while parser is in EXT_BRK with KEYS_HELD=8'h21 -> next cycle all outputs at reset values. Following byte 1B -> CMD_START pulse.
- Strobe jitter: toggle SCAN_STROBE asynchronously to CLK (random phase, 10 bytes) -> exactly 10 byte_valid events, and each captured byte equals its SCAN_DATA.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, direction and parser types for the keyboard front end.
// Also holds the scan-code to KEYS_HELD bit lookup used by the decoder.
package ps2_pkg;

  localparam logic [7:0] CodeErr   = 8'h00;
  localparam logic [7:0] CodeE0    = 8'hE0;
  localparam logic [7:0] CodeF0    = 8'hF0;
  localparam logic [7:0] CodeUp    = 8'h75;
  localparam logic [7:0] CodeRight = 8'h74;
  localparam logic [7:0] CodeDown  = 8'h72;
  localparam logic [7:0] CodeLeft  = 8'h6B;
  localparam logic [7:0] CodeEsc   = 8'h76;
  localparam logic [7:0] CodeS     = 8'h1B;
  localparam logic [7:0] CodeP     = 8'h4D;
  localparam logic [7:0] CodeR     = 8'h2D;

  // KEYS_HELD bit positions; arrow indices double as direction encodings.
  localparam logic [2:0] KeyUp    = 3'd0;
  localparam logic [2:0] KeyRight = 3'd1;
  localparam logic [2:0] KeyDown  = 3'd2;
  localparam logic [2:0] KeyLeft  = 3'd3;
  localparam logic [2:0] KeyEsc   = 3'd4;
  localparam logic [2:0] KeyS     = 3'd5;
  localparam logic [2:0] KeyP     = 3'd6;
  localparam logic [2:0] KeyR     = 3'd7;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirRight = 2'd1,
    DirDown  = 2'd2,
    DirLeft  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } parse_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Arrows map with or without the E0 prefix; the other keys only without it.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t res;
    res.hit = 1'b1;
    res.idx = KeyUp;
    case (code)
      CodeUp:    res.idx = KeyUp;
      CodeRight: res.idx = KeyRight;
      CodeDown:  res.idx = KeyDown;
      CodeLeft:  res.idx = KeyLeft;
      CodeEsc: begin
        res.idx = KeyEsc;
        res.hit = ~ext;
      end
      CodeS: begin
        res.idx = KeyS;
        res.hit = ~ext;
      end
      CodeP: begin
        res.idx = KeyP;
        res.hit = ~ext;
      end
      CodeR: begin
        res.idx = KeyR;
        res.hit = ~ext;
      end
      default: res.hit = 1'b0;
    endcase
    return res;
  endfunction

  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/ps2_strobe_sync.sv
// Brings the PS2_CLK-domain data strobe into the system clock domain and emits a one-cycle
// valid pulse together with the data word captured on that same edge.
module ps2_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_strobe,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic                   r_valid;
  logic [DATA_W-1:0]      r_data;
  logic                   w_rise;

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_last;

  // i_data is stable from strobe rise until the next rise, so sampling it here is safe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_strobe};
      r_last  <= r_sync[SYNC_STAGES-1];
      r_valid <= w_rise;
      if (w_rise) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ps2_key_decoder.sv
// Parses make/break/extended PS/2 sequences into a held-key bitmap, game command pulses and a
// tick-committed snake direction that never reverses onto itself.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PREFIX_TIMEOUT = 1000000,
  parameter logic [1:0]  RESET_DIR      = 2'd1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scan_strobe,
  input  logic [7:0] i_scan_data,
  input  logic       i_game_tick,
  output logic [1:0] o_dir,
  output logic       o_dir_changed,
  output logic [7:0] o_keys_held,
  output logic       o_cmd_start,
  output logic       o_cmd_restart,
  output logic       o_cmd_esc,
  output logic       o_paused
);

  localparam int unsigned TmoW = ($clog2(PREFIX_TIMEOUT) > 0) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(PREFIX_TIMEOUT - 1);

  logic         w_byte_valid;
  logic [7:0]   w_byte;
  parse_state_t r_state;
  parse_state_t w_state_next;
  logic [TmoW-1:0] r_tmo_cnt;
  logic         w_tmo_hit;
  logic         w_make;
  logic         w_break;
  logic         w_ext;
  key_hit_t     w_key;
  logic         w_new_press;

  dir_t       r_dir;
  dir_t       r_pending;
  logic       r_dir_changed;
  logic [7:0] r_keys;
  logic       r_cmd_start;
  logic       r_cmd_restart;
  logic       r_cmd_esc;
  logic       r_paused;

  ps2_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DATA_W      (8)
  ) u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_scan_strobe),
    .i_data   (i_scan_data),
    .o_valid  (w_byte_valid),
    .o_data   (w_byte)
  );

  assign w_tmo_hit = (r_state != StIdle) && (r_tmo_cnt == TmoLast);

  // Byte 00 is an overrun marker: it neither produces an event nor disturbs a pending prefix.
  always_comb begin
    w_state_next = r_state;
    w_make       = 1'b0;
    w_break      = 1'b0;
    w_ext        = 1'b0;
    if (w_byte_valid) begin
      if (w_byte != CodeErr) begin
        case (r_state)
          StIdle: begin
            if (w_byte == CodeE0) begin
              w_state_next = StExt;
            end else if (w_byte == CodeF0) begin
              w_state_next = StBrk;
            end else begin
              w_make = 1'b1;
            end
          end
          StExt: begin
            if (w_byte == CodeF0) begin
              w_state_next = StExtBrk;
            end else if (w_byte != CodeE0) begin
              w_make       = 1'b1;
              w_ext        = 1'b1;
              w_state_next = StIdle;
            end
          end
          StBrk: begin
            w_break      = 1'b1;
            w_state_next = StIdle;
          end
          StExtBrk: begin
            w_break      = 1'b1;
            w_ext        = 1'b1;
            w_state_next = StIdle;
          end
          default: w_state_next = StIdle;
        endcase
      end
    end else if (w_tmo_hit) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (w_byte_valid || (r_state == StIdle) || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
    end
  end

  always_comb begin
    w_key       = key_lookup(w_byte, w_ext);
    w_new_press = w_make && w_key.hit && !r_keys[w_key.idx];
  end

  // A tick and a press in the same cycle: the tick commits the old pending value because both
  // registers update on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dir         <= dir_t'(RESET_DIR);
      r_pending     <= dir_t'(RESET_DIR);
      r_dir_changed <= 1'b0;
      r_keys        <= '0;
      r_cmd_start   <= 1'b0;
      r_cmd_restart <= 1'b0;
      r_cmd_esc     <= 1'b0;
      r_paused      <= 1'b0;
    end else begin
      r_dir_changed <= 1'b0;
      r_cmd_start   <= 1'b0;
      r_cmd_restart <= 1'b0;
      r_cmd_esc     <= 1'b0;
      if (i_game_tick) begin
        r_dir         <= r_pending;
        r_dir_changed <= (r_pending != r_dir);
      end
      if (w_new_press) begin
        r_keys[w_key.idx] <= 1'b1;
        case (w_key.idx)
          KeyUp, KeyRight, KeyDown, KeyLeft: begin
            if (dir_t'(w_key.idx[1:0]) != dir_opposite(r_dir)) begin
              r_pending <= dir_t'(w_key.idx[1:0]);
            end
          end
          KeyEsc: r_cmd_esc <= 1'b1;
          KeyS: begin
            r_cmd_start <= 1'b1;
            r_paused    <= 1'b0;
          end
          KeyP: r_paused <= ~r_paused;
          KeyR: begin
            r_cmd_restart <= 1'b1;
            r_pending     <= dir_t'(RESET_DIR);
          end
          default: ;
        endcase
      end else if (w_break && w_key.hit) begin
        r_keys[w_key.idx] <= 1'b0;
      end
    end
  end

  assign o_dir         = r_dir;
  assign o_dir_changed = r_dir_changed;
  assign o_keys_held   = r_keys;
  assign o_cmd_start   = r_cmd_start;
  assign o_cmd_restart = r_cmd_restart;
  assign o_cmd_esc     = r_cmd_esc;
  assign o_paused      = r_paused;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized bench for ps2_key_decoder, checked against a byte-level model of
// the key-sequence rules kept in this file.
module tb_ps2_key_decoder;

  localparam int unsigned Timeout  = 64;
  localparam int          ResetDir = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe;
  logic [7:0] data;
  logic       tick;
  logic [1:0] o_dir;
  logic       o_dir_changed;
  logic [7:0] o_keys_held;
  logic       o_cmd_start;
  logic       o_cmd_restart;
  logic       o_cmd_esc;
  logic       o_paused;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .SYNC_STAGES    (2),
    .PREFIX_TIMEOUT (Timeout),
    .RESET_DIR      (2'd1)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_scan_strobe (strobe),
    .i_scan_data   (data),
    .i_game_tick   (tick),
    .o_dir         (o_dir),
    .o_dir_changed (o_dir_changed),
    .o_keys_held   (o_keys_held),
    .o_cmd_start   (o_cmd_start),
    .o_cmd_restart (o_cmd_restart),
    .o_cmd_esc     (o_cmd_esc),
    .o_paused      (o_paused)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int cnt_dc = 0, cnt_start = 0, cnt_restart = 0, cnt_esc = 0;
  logic [7:0] q_cap[$];
  logic [7:0] q_sent[$];

  always @(negedge clk) begin
    if (o_dir_changed) cnt_dc <= cnt_dc + 1;
    if (o_cmd_start)   cnt_start <= cnt_start + 1;
    if (o_cmd_restart) cnt_restart <= cnt_restart + 1;
    if (o_cmd_esc)     cnt_esc <= cnt_esc + 1;
    if (dut.w_byte_valid) q_cap.push_back(dut.w_byte);
  end

  // Reference model state
  int         m_dir, m_pend;
  logic [7:0] m_held;
  bit         m_paused, m_e0, m_f0;
  int         e_dc = 0, e_start = 0, e_restart = 0, e_esc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int key_of(input logic [7:0] code, input bit ext);
    case (code)
      8'h75: return 0;
      8'h74: return 1;
      8'h72: return 2;
      8'h6B: return 3;
      8'h76: return ext ? -1 : 4;
      8'h1B: return ext ? -1 : 5;
      8'h4D: return ext ? -1 : 6;
      8'h2D: return ext ? -1 : 7;
      default: return -1;
    endcase
  endfunction

  task automatic m_reset();
    m_dir = ResetDir; m_pend = ResetDir; m_held = '0;
    m_paused = 0; m_e0 = 0; m_f0 = 0;
  endtask

  task automatic m_make(input int k);
    if (k < 0) return;
    if (m_held[k]) return;
    m_held[k] = 1'b1;
    if (k < 4) begin
      if (k != ((m_dir + 2) % 4)) m_pend = k;
    end else if (k == 4) e_esc++;
    else if (k == 5) begin e_start++; m_paused = 0; end
    else if (k == 6) m_paused = ~m_paused;
    else begin e_restart++; m_pend = ResetDir; end
  endtask

  task automatic m_byte(input logic [7:0] b);
    int k;
    if (b == 8'h00) return;
    if (m_f0) begin
      k = key_of(b, m_e0);
      if (k >= 0) m_held[k] = 1'b0;
      m_e0 = 0; m_f0 = 0;
    end else if (b == 8'hE0) m_e0 = 1;
    else if (b == 8'hF0) m_f0 = 1;
    else begin
      m_make(key_of(b, m_e0));
      m_e0 = 0;
    end
  endtask

  task automatic m_commit(input int p);
    if (p != m_dir) e_dc++;
    m_dir = p;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " dir"}, 32'(o_dir), 32'(m_dir));
    check_eq({tag, " keys"}, 32'(o_keys_held), 32'(m_held));
    check_eq({tag, " paused"}, 32'(o_paused), 32'(m_paused));
    check_eq({tag, " dir_changed count"}, 32'(cnt_dc), 32'(e_dc));
    check_eq({tag, " start count"}, 32'(cnt_start), 32'(e_start));
    check_eq({tag, " restart count"}, 32'(cnt_restart), 32'(e_restart));
    check_eq({tag, " esc count"}, 32'(cnt_esc), 32'(e_esc));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data = b; strobe = 1'b1;
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
    m_byte(b);
  endtask

  // Aligns the tick with the cycle in which the byte is parsed.
  task automatic send_byte_tick(input logic [7:0] b);
    int old_pend;
    @(negedge clk);
    data = b; strobe = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; strobe = 1'b0;
    repeat (4) @(negedge clk);
    old_pend = m_pend;
    m_byte(b);
    m_commit(old_pend);
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    m_commit(m_pend);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] pool [12];
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B, 8'h76, 8'h1B, 8'h4D, 8'h2D, 8'h00, 8'hF0};
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(1, 255));
    return pool[$urandom_range(0, 11)];
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1; strobe = 1'b0; tick = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    check_all("reset");
    check_eq("reset dir value", 32'(o_dir), 32'd1);

    // Reset while E0 F0 is pending with UP and S held
    send_byte(8'h75); send_byte(8'h1B);
    check_eq("held before reset", 32'(o_keys_held), 32'h21);
    send_byte(8'hE0); send_byte(8'hF0);
    do_reset();
    check_all("mid-sequence reset");
    check_eq("reset pulses", 32'({o_cmd_start, o_cmd_restart, o_cmd_esc, o_dir_changed}), 32'd0);
    send_byte(8'h1B);
    check_all("start after reset");

    // Extended UP then tick
    send_byte(8'hE0); send_byte(8'h75);
    check_eq("ext up held", 32'(o_keys_held[0]), 32'd1);
    do_tick();
    check_all("tick up");
    check_eq("dir up", 32'(o_dir), 32'd0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_all("release up");

    // Reversal rejection
    send_byte(8'h74); do_tick(); send_byte(8'hF0); send_byte(8'h74);
    check_all("right");
    send_byte(8'h6B); do_tick();
    check_eq("reverse rejected", 32'(o_dir), 32'd1);
    check_all("reverse");
    send_byte(8'hF0); send_byte(8'h6B);
    send_byte(8'h72); do_tick();
    check_eq("dir down", 32'(o_dir), 32'd2);
    check_all("down");

    // Typematic P then release and press again
    repeat (3) send_byte(8'h4D);
    check_eq("pause once", 32'(o_paused), 32'd1);
    send_byte(8'hF0); send_byte(8'h4D); send_byte(8'h4D);
    check_eq("unpause", 32'(o_paused), 32'd0);
    check_all("pause");
    send_byte(8'hF0); send_byte(8'h4D);

    // Prefix survives a gap shorter than the timeout
    send_byte(8'hE0);
    repeat (40) @(negedge clk);
    send_byte(8'h4D);
    check_all("prefix kept");
    // Prefix dropped after the timeout
    send_byte(8'hE0);
    repeat (Timeout + 16) @(negedge clk);
    m_e0 = 0; m_f0 = 0;
    send_byte(8'h4D);
    check_eq("timeout to idle", 32'(o_paused), 32'd1);
    check_all("timeout");
    send_byte(8'hF0); send_byte(8'h4D);
    send_byte(8'hE0);
    repeat (Timeout + 16) @(negedge clk);
    m_e0 = 0; m_f0 = 0;
    send_byte(8'h74);
    check_all("timeout right");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    check_eq("ext break right", 32'(o_keys_held[1]), 32'd0);

    // Press and tick in the same cycle
    do_tick();
    send_byte_tick(8'h75);
    check_all("same-cycle tick");
    do_tick();
    check_all("next tick");

    // Randomized stream
    for (int i = 0; i < 250; i++) begin
      b = rand_code();
      if ($urandom_range(0, 9) == 0) send_byte_tick(b);
      else send_byte(b);
      if ($urandom_range(0, 3) == 0) do_tick();
      if ($urandom_range(0, 79) == 0) do_reset();
      check_all($sformatf("rand %0d", i));
    end

    // Asynchronous strobe with random phase
    send_byte(8'hF0); send_byte(8'h01);
    q_cap.delete(); q_sent.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(1, 15));
      #($urandom_range(31, 67));
      data = b; strobe = 1'b1;
      q_sent.push_back(b);
      #($urandom_range(31, 67));
      strobe = 1'b0;
    end
    repeat (10) @(negedge clk);
    check_eq("jitter byte count", 32'(q_cap.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < q_cap.size()) check_eq($sformatf("jitter byte %0d", i), 32'(q_cap[i]), 32'(q_sent[i]));
      m_byte(q_sent[i]);
    end
    check_all("after jitter");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
